// File: rtl/biquad8_pkg.sv
// ============================================================================
// Module      : biquad8_pkg
// Description : Shared constants and state encoding for the biquad8
//               coefficient loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package biquad8_pkg;

    localparam int COEFF_BITS         = 18;  // DSP B-port width, signed Q4.14
    localparam int COEFF_FRAC_BITS    = 14;
    localparam int NCOEFF_INCREMENTAL = 2;   // a, b of 1 + a*z^-1 + b*z^-2

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD   = 2'd1;
    localparam logic [STATE_W-1:0] ST_UPDATE = 2'd2;
    localparam logic [STATE_W-1:0] ST_FIN    = 2'd3;

    // A one-entry burst still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/biquad8_coeff_loader.sv
// ============================================================================
// Module      : biquad8_coeff_loader
// Description : Shadow coefficient bank plus burst sequencer driving the
//               biquad8 incremental cascade (write burst, then update strobe).
//               Optional readback of the active bank: BIQUAD_COEFF_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int NCOEFF    = NCOEFF_INCREMENTAL,
    parameter int NBITS     = COEFF_BITS,
    parameter int ADDR_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [NBITS-1:0]     wr_dat_i,
    input  logic                 commit_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 coeff_wr_o,
    output logic                 coeff_update_o,
    output logic [NBITS-1:0]     coeff_dat_o
`ifdef BIQUAD_COEFF_READBACK_EN
    ,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [NBITS-1:0]     rd_dat_o
`endif
);

    localparam int                CNT_W    = cnt_width(NCOEFF);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NCOEFF - 1);

    logic [NBITS-1:0]   r_shadow [NCOEFF];
    logic [NBITS-1:0]   r_snap   [NCOEFF];
    logic [NBITS-1:0]   w_shadow_wt [NCOEFF];

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_pending;
    logic               w_start;
    logic [NBITS-1:0]   w_dat_nxt;

    // Write-through view: a write in the commit cycle lands in the snapshot.
    // Out-of-range addresses match no index and are dropped.
    for (genvar i = 0; i < NCOEFF; i++) begin : g_shadow
        assign w_shadow_wt[i] = (wr_en_i && (wr_addr_i == ADDR_BITS'(i)))
                                ? wr_dat_i : r_shadow[i];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (commit_i || r_pending) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_UPDATE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_UPDATE: w_state_nxt = ST_FIN;
            ST_FIN: begin
                // Pending burst restarts straight from FIN with no idle gap.
                if (r_pending) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_dat_nxt = coeff_dat_o;
        if (w_start) begin
            w_dat_nxt = w_shadow_wt[0];
        end else if (r_state == ST_LOAD && r_cnt != CNT_LAST) begin
            w_dat_nxt = r_snap[w_cnt_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCOEFF; i++) begin
                r_shadow[i] <= '0;
                r_snap[i]   <= '0;
            end
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_pending      <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;
            coeff_dat_o    <= '0;
        end else begin
            for (int i = 0; i < NCOEFF; i++) begin
                r_shadow[i] <= w_shadow_wt[i];
                if (w_start) begin
                    r_snap[i] <= w_shadow_wt[i];
                end
            end
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            // One-deep pending: extra commits merge; a starting burst absorbs
            // any commit arriving in its own start cycle.
            r_pending <= w_start ? 1'b0
                                 : (r_pending | (commit_i && r_state != ST_IDLE));
            busy_o         <= (w_state_nxt != ST_IDLE);
            done_o         <= (w_state_nxt == ST_FIN);
            coeff_wr_o     <= (w_state_nxt == ST_LOAD);
            coeff_update_o <= (w_state_nxt == ST_UPDATE);
            coeff_dat_o    <= w_dat_nxt;
        end
    end

`ifdef BIQUAD_COEFF_READBACK_EN
    // Active bank mirrors what the DSPs latched on the update strobe.
    logic [NBITS-1:0] r_active [NCOEFF];
    logic [NBITS-1:0] w_rd_val;

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NCOEFF; i++) begin
            if (rd_addr_i == ADDR_BITS'(i)) begin
                w_rd_val = r_active[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCOEFF; i++) begin
                r_active[i] <= '0;
            end
            rd_dat_o <= '0;
        end else begin
            if (r_state == ST_UPDATE) begin
                for (int i = 0; i < NCOEFF; i++) begin
                    r_active[i] <= r_snap[i];
                end
            end
            rd_dat_o <= w_rd_val;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_biquad8_coeff_loader.sv
// ============================================================================
// Module      : tb_biquad8_coeff_loader
// Description : Scoreboard bench for biquad8_coeff_loader (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_biquad8_coeff_loader;

    localparam int NB = 18;
    localparam int AB = 2;

    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_UPD = 2'd2;
    localparam logic [1:0] K_DN  = 2'd3;

    typedef struct packed {
        logic [1:0]    kind;
        logic [NB-1:0] dat;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en_i = 1'b0;
    logic [AB-1:0] wr_addr_i = '0;
    logic [NB-1:0] wr_dat_i = '0;
    logic          commit_i = 1'b0;
    logic          busy_o, done_o, coeff_wr_o, coeff_update_o;
    logic [NB-1:0] coeff_dat_o;
    logic [AB-1:0] rd_addr_i = '0;
`ifdef BIQUAD_COEFF_READBACK_EN
    logic [NB-1:0] rd_dat_o;
`endif

    int   total = 0;
    int   bad   = 0;
    logic [31:0] cyc = 0;
    logic [31:0] tc;
    exp_t q[$];

    biquad8_coeff_loader #(.NCOEFF(2), .NBITS(NB), .ADDR_BITS(AB)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_dat_i       (wr_dat_i),
        .commit_i       (commit_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .coeff_wr_o     (coeff_wr_o),
        .coeff_update_o (coeff_update_o),
        .coeff_dat_o    (coeff_dat_o)
`ifdef BIQUAD_COEFF_READBACK_EN
        ,
        .rd_addr_i      (rd_addr_i),
        .rd_dat_o       (rd_dat_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [NB-1:0] d, input logic [31:0] c);
        exp_t e;
        e.kind = k; e.dat = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Burst committed at edge c: two writes, update, done on consecutive cycles.
    task automatic push_burst(input logic [31:0] c, input logic [NB-1:0] d0, input logic [NB-1:0] d1);
        push(K_WR,  d0, c);
        push(K_WR,  d1, c + 1);
        push(K_UPD, d1, c + 2);
        push(K_DN,  d1, c + 3);
    endtask

    task automatic shadow_write(input logic [AB-1:0] a, input logic [NB-1:0] d);
        wr_en_i = 1'b1; wr_addr_i = a; wr_dat_i = d;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every strobe from the DUT must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (coeff_wr_o && coeff_update_o)
                check("wr_and_update", 32'd1, 32'd0);
            if (coeff_wr_o || coeff_update_o || done_o) begin
                exp_t e;
                logic [1:0] k;
                k = coeff_wr_o ? K_WR : (coeff_update_o ? K_UPD : K_DN);
                check("sb_nonempty", (q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("out_kind", 32'(k), 32'(e.kind));
                    check("out_dat",  32'(coeff_dat_o), 32'(e.dat));
                    check("out_cyc",  cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_wr",   32'(coeff_wr_o), 32'd0);
        check("rst_upd",  32'(coeff_update_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_dat",  32'(coeff_dat_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic burst; address 2 is out of range and must not alias.
        shadow_write(2'd0, 18'h0C000);
        shadow_write(2'd1, 18'h3F000);
        shadow_write(2'd2, 18'h2AAAA);
        commit_i = 1'b1; tc = cyc + 1;
        push_burst(tc, 18'h0C000, 18'h3F000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            commit_i = 1'b0;
            check("busy_window", 32'(busy_o), (k < 4) ? 32'd1 : 32'd0);
        end
        wait_idle();
`ifdef BIQUAD_COEFF_READBACK_EN
        rd_addr_i = 2'd1;
        @(negedge clk);
        check("rd_addr1", 32'(rd_dat_o), 32'h3F000);
        rd_addr_i = 2'd3;
        @(negedge clk);
        check("rd_out_of_range", 32'(rd_dat_o), 32'd0);
        rd_addr_i = 2'd0;
`endif

        // Commit with a same-cycle write to index 1.
        commit_i = 1'b1; tc = cyc + 1;
        wr_en_i = 1'b1; wr_addr_i = 2'd1; wr_dat_i = 18'h01234;
        push_burst(tc, 18'h0C000, 18'h01234);
        @(negedge clk);
        commit_i = 1'b0; wr_en_i = 1'b0;
        wait_idle();

        // Commit during burst; pending burst snapshots a later shadow write.
        commit_i = 1'b1; tc = cyc + 1;
        push_burst(tc,     18'h0C000, 18'h01234);
        push_burst(tc + 4, 18'h00001, 18'h01234);
        @(negedge clk);
        commit_i = 1'b0;
        @(negedge clk);
        commit_i = 1'b1;
        @(negedge clk);
        commit_i = 1'b0;
        wr_en_i = 1'b1; wr_addr_i = 2'd0; wr_dat_i = 18'h00001;
        @(negedge clk);
        wr_en_i = 1'b0;
        repeat (2) @(negedge clk);
`ifdef BIQUAD_COEFF_READBACK_EN
        check("rd_before_update", 32'(rd_dat_o), 32'h0C000);
`endif
        repeat (3) @(negedge clk);
`ifdef BIQUAD_COEFF_READBACK_EN
        check("rd_after_update", 32'(rd_dat_o), 32'h00001);
`endif
        wait_idle();

        // Commits held over three extra edges merge into one extra burst.
        commit_i = 1'b1; tc = cyc + 1;
        push_burst(tc,     18'h00001, 18'h01234);
        push_burst(tc + 4, 18'h00001, 18'h01234);
        repeat (4) @(negedge clk);
        commit_i = 1'b0;
        repeat (12) @(negedge clk);
        wait_idle();

        // Asynchronous reset mid-burst: only the first write escapes.
        commit_i = 1'b1; tc = cyc + 1;
        push(K_WR, 18'h00001, tc);
        @(negedge clk);
        commit_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_wr",   32'(coeff_wr_o), 32'd0);
        check("arst_upd",  32'(coeff_update_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_dat",  32'(coeff_dat_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_sb_empty", 32'(q.size()), 32'd0);
`ifdef BIQUAD_COEFF_READBACK_EN
        rd_addr_i = 2'd1;
        @(negedge clk);
        check("rd_after_reset", 32'(rd_dat_o), 32'd0);
`endif
        commit_i = 1'b1; tc = cyc + 1;
        push_burst(tc, 18'h00000, 18'h00000);
        @(negedge clk);
        commit_i = 1'b0;
        wait_idle();

        check("sb_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
